// File: rtl/activation_pipe.sv
// Two-stage activation pipeline: S1 applies the fixed-point shift and the selected activation,
// S2 saturates each lane to OUT_W bits. A ready/valid handshake with skid-free backpressure wraps both stages.
module activation_pipe #(
  parameter int LANES      = 4,
  parameter int IN_W       = 16,
  parameter int OUT_W      = 8,
  parameter int FRAC_SHIFT = 4,
  parameter int CLIP       = 96
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   DI_valid,
  output logic                   DI_ready,
  input  logic [LANES*IN_W-1:0]  DI,
  input  logic [1:0]             mode,
  output logic                   DO_valid,
  input  logic                   DO_ready,
  output logic [LANES*OUT_W-1:0] DO,
  output logic [15:0]            sat_cnt,
  input  logic                   sat_clr
);

  typedef enum logic [1:0] {
    MODE_IDENT = 2'b00,
    MODE_RELU  = 2'b01,
    MODE_CLIP  = 2'b10,
    MODE_LEAKY = 2'b11
  } act_mode_e;

  localparam int OUT_MAX_I = 2 ** (OUT_W - 1) - 1;
  localparam logic signed [IN_W-1:0] OUT_MAX = IN_W'(OUT_MAX_I);
  localparam logic signed [IN_W-1:0] OUT_MIN = IN_W'(-OUT_MAX_I - 1);
  localparam logic signed [IN_W-1:0] CLIP_V  = IN_W'(CLIP);

  function automatic logic signed [IN_W-1:0] activate(input logic signed [IN_W-1:0] x,
                                                      input logic [1:0] m);
    logic signed [IN_W-1:0] s;
    s = x >>> FRAC_SHIFT;
    case (act_mode_e'(m))
      MODE_IDENT: activate = s;
      MODE_RELU:  activate = (s < 0) ? '0 : s;
      MODE_CLIP:  activate = (s < 0) ? '0 : ((s > CLIP_V) ? CLIP_V : s);
      default:    activate = (s < 0) ? (s >>> 3) : s;
    endcase
  endfunction

  logic                   s1_valid, s2_valid;
  logic                   s1_load, s2_load, do_fire;
  logic signed [IN_W-1:0] s1_act   [LANES];
  logic signed [IN_W-1:0] act_next [LANES];
  logic [LANES*OUT_W-1:0] do_next;
  logic [LANES-1:0]       flag_next, s2_flag;
  logic [16:0]            cnt_sum;

  // A stage may refill whenever its current content leaves on the same edge.
  assign do_fire  = s2_valid & DO_ready;
  assign s2_load  = ~s2_valid | DO_ready;
  assign s1_load  = ~s1_valid | s2_load;
  assign DI_ready = s1_load;
  assign DO_valid = s2_valid;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    do_next   = '0;
    flag_next = '0;
    cnt_sum   = {1'b0, sat_cnt};
    for (int k = 0; k < LANES; k++) begin
      act_next[k] = activate(DI[k*IN_W +: IN_W], mode);
      if (s1_act[k] > OUT_MAX) begin
        do_next[k*OUT_W +: OUT_W] = OUT_MAX[OUT_W-1:0];
        flag_next[k]              = 1'b1;
      end else if (s1_act[k] < OUT_MIN) begin
        do_next[k*OUT_W +: OUT_W] = OUT_MIN[OUT_W-1:0];
        flag_next[k]              = 1'b1;
      end else begin
        do_next[k*OUT_W +: OUT_W] = s1_act[k][OUT_W-1:0];
      end
      cnt_sum = cnt_sum + 17'(s2_flag[k]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= DI_valid;
    end
  end

  // NOTE: S1 data carries no reset; s1_valid alone qualifies it, so reset fan-out stays off the datapath.
  always_ff @(posedge clk) begin
    if (s1_load && DI_valid) begin
      for (int k = 0; k < LANES; k++) s1_act[k] <= act_next[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      DO       <= '0;
      s2_flag  <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        DO      <= do_next;
        s2_flag <= flag_next;
      end
    end
  end

  // Clear wins over a same-edge increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_cnt <= '0;
    end else if (sat_clr) begin
      sat_cnt <= '0;
    end else if (do_fire) begin
      sat_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

endmodule

// File: tb/tb_activation_pipe.sv
// Self-checking bench for activation_pipe: a queue-based behavioural model checked every cycle,
// plus directed literal beats, stall, mid-stream reset and counter saturation scenarios.
`timescale 1ns/1ps
module tb_activation_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        DI_valid = 1'b0;
  logic        DI_ready;
  logic [63:0] DI = '0;
  logic [1:0]  mode = 2'b00;
  logic        DO_valid;
  logic        DO_ready = 1'b1;
  logic [31:0] DO;
  logic [15:0] sat_cnt;
  logic        sat_clr = 1'b0;

  activation_pipe #(.LANES(4), .IN_W(16), .OUT_W(8), .FRAC_SHIFT(4), .CLIP(96)) dut (
    .clk(clk), .rst(rst), .DI_valid(DI_valid), .DI_ready(DI_ready), .DI(DI), .mode(mode),
    .DO_valid(DO_valid), .DO_ready(DO_ready), .DO(DO), .sat_cnt(sat_cnt), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit rand_rdy = 1'b0;

  logic [31:0] exp_q[$];
  int          exp_sat_q[$];
  int          m_cnt = 0;
  bit          stall_prev = 1'b0;
  logic [31:0] stall_do;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference arithmetic on plain ints: floor shift, activation, then clamp to the 8-bit range.
  function automatic void model_beat(input logic [63:0] d, input logic [1:0] m,
                                     output logic [31:0] o, output int nsat);
    nsat = 0;
    o    = '0;
    for (int k = 0; k < 4; k++) begin
      int x, s, a;
      x = int'($signed(d[k*16 +: 16]));
      s = x >>> 4;
      case (m)
        2'b00:   a = s;
        2'b01:   a = (s < 0) ? 0 : s;
        2'b10:   a = (s < 0) ? 0 : ((s > 96) ? 96 : s);
        default: a = (s < 0) ? (s >>> 3) : s;
      endcase
      if (a > 127) begin a = 127; nsat++; end
      else if (a < -128) begin a = -128; nsat++; end
      o[k*8 +: 8] = a[7:0];
    end
  endfunction

  // Compare process: all sampling on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [31:0] e;
    int n;
    if (!rst) begin
      exp_q.delete();
      exp_sat_q.delete();
      m_cnt      = 0;
      stall_prev = 1'b0;
      check("reset_do_valid", DO_valid, 0);
      check("reset_do", DO, 0);
      check("reset_sat_cnt", sat_cnt, 0);
    end else begin
      check("sat_cnt", sat_cnt, m_cnt);
      if (stall_prev) begin
        check("stall_do_valid", DO_valid, 1);
        check("stall_do_hold", DO, stall_do);
      end
      if (DO_valid && DO_ready) begin
        if (exp_q.size() == 0) check("unexpected_beat", DO_valid, 0);
        else begin
          e = exp_q.pop_front();
          n = exp_sat_q.pop_front();
          check("do_beat", DO, e);
          m_cnt = (m_cnt + n > 65535) ? 65535 : m_cnt + n;
        end
      end
      if (sat_clr) m_cnt = 0;
      stall_prev = DO_valid && !DO_ready;
      stall_do   = DO;
      if (DI_valid && DI_ready) begin
        model_beat(DI, mode, e, n);
        exp_q.push_back(e);
        exp_sat_q.push_back(n);
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_rdy) DO_ready = 1'($urandom_range(0, 1));
  end

  task automatic push(input logic [63:0] d, input logic [1:0] m);
    int guard = 0;
    DI = d; mode = m; DI_valid = 1'b1;
    do begin @(negedge clk); guard++; end while (!DI_ready && guard < 200);
    if (!DI_ready) check("push_timeout", DI_ready, 1);
    @(posedge clk); #1;
    DI_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    do begin @(negedge clk); guard++; end while ((exp_q.size() != 0 || DO_valid) && guard < 2000);
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] rand_lane();
    case ($urandom_range(0, 4))
      0:       rand_lane = 16'h8000;
      1:       rand_lane = 16'h7FFF;
      2:       rand_lane = 16'($urandom_range(0, 4095)) - 16'd2048;
      default: rand_lane = 16'($urandom);
    endcase
  endfunction

  function automatic logic [63:0] rand_beat();
    rand_beat = {rand_lane(), rand_lane(), rand_lane(), rand_lane()};
  endfunction

  logic [63:0] dir_d [5] = '{64'h7FF0_0000_FFE0_0123, 64'h7FF0_0000_FFE0_0123,
                             64'h7FF0_0000_FFE0_0123, 64'h7FF0_0000_FFE0_0123,
                             64'h0000_0000_0000_8000};
  logic [1:0]  dir_m [5] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b00};
  logic [31:0] dir_o [5] = '{32'h7F00_0012, 32'h7F00_FE12, 32'h6000_0012, 32'h7F00_FF12,
                             32'h0000_0080};
  logic [15:0] dir_c [5] = '{16'd0, 16'd1, 16'd2, 16'd2, 16'd3};

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("post_reset_di_ready", DI_ready, 1);

    // Directed literal beats, back-to-back, exact two-cycle latency.
    DO_ready = 1'b1;
    @(posedge clk); #1;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          DI = dir_d[k]; mode = dir_m[k]; DI_valid = 1'b1;
          @(negedge clk);
          check("dir_di_ready", DI_ready, 1);
          @(posedge clk); #1;
        end
        DI_valid = 1'b0;
      end
      begin
        @(negedge clk); check("latency_c0", DO_valid, 0);
        @(negedge clk); check("latency_c1", DO_valid, 0);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("dir_valid", DO_valid, 1);
          check("dir_do", DO, dir_o[k]);
          check("dir_sat_cnt", sat_cnt, dir_c[k]);
        end
        @(negedge clk);
        check("dir_sat_final", sat_cnt, 16'd4);
        check("dir_idle", DO_valid, 0);
      end
    join
    drain();

    // Eight-beat stream with a five-cycle stall once two beats are buffered.
    DO_ready = 1'b0;
    push(rand_beat(), 2'($urandom_range(0, 3)));
    push(rand_beat(), 2'($urandom_range(0, 3)));
    DI = rand_beat(); mode = 2'($urandom_range(0, 3)); DI_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_di_ready", DI_ready, 0);
    end
    rand_rdy = 1'b1;
    push(DI, mode);
    for (int i = 0; i < 5; i++) push(rand_beat(), 2'($urandom_range(0, 3)));
    drain();

    // Randomized traffic with random backpressure and occasional clears.
    for (int i = 0; i < 300; i++) begin
      sat_clr = ($urandom_range(0, 15) == 0);
      push(rand_beat(), 2'($urandom_range(0, 3)));
    end
    sat_clr = 1'b0;
    drain();

    // Asynchronous reset pulse between edges with both stages full.
    rand_rdy = 1'b0;
    DO_ready = 1'b0;
    push(64'h7FFF_7FFF_0123_8000, 2'b00);
    push(64'h1234_8000_FFE0_0100, 2'b11);
    @(posedge clk); #2;
    check("pre_rst_full", DO_valid, 1);
    rst = 1'b0;
    #1;
    check("rst_async_do_valid", DO_valid, 0);
    check("rst_async_do", DO, 0);
    check("rst_async_sat_cnt", sat_cnt, 0);
    #5 rst = 1'b1;
    @(negedge clk);
    check("rst_release_di_ready", DI_ready, 1);
    DO_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("rst_no_stale", DO_valid, 0);
    end
    @(posedge clk); #1;

    // Drive sat_cnt up to 0xFFFE, then saturate and clear it.
    for (int i = 0; i < 16383; i++) push(64'h7FFF_7FFF_7FFF_7FFF, 2'b00);
    push(64'h0000_0000_7FFF_7FFF, 2'b00);
    drain();
    check("sat_fffe", sat_cnt, 16'hFFFE);
    push(64'h7FFF_8000_7FFF_8000, 2'b00);
    drain();
    check("sat_ffff", sat_cnt, 16'hFFFF);
    push(64'h7FFF_7FFF_7FFF_7FFF, 2'b11);
    drain();
    check("sat_no_wrap", sat_cnt, 16'hFFFF);
    sat_clr = 1'b1;
    push(64'h7FFF_7FFF_7FFF_7FFF, 2'b00);
    drain();
    check("sat_clr_priority", sat_cnt, 16'h0000);
    sat_clr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
